// File: rtl/stopwatch_ctrl_fsm.sv
// stopwatch_ctrl_fsm: run-control sequencer for the stopwatch.
// Debounces start/stop, lap and clear, runs the run/pause/lap state machine,
// drives counter/display enables, pulses the counter clear and issues
// refresh requests to the SPI driver over a req/ack handshake.
// Optional feature macro: SW_AUTO_STOP_EN (stop the count at 59:59:99).
module stopwatch_ctrl_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned DB_W            = 14
) (
  input  logic       clk,
  input  logic       res,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic       tick_100hz,
  input  logic       at_max,
  input  logic       refresh_ack,
  output logic       counter_enable,
  output logic       display_enable,
  output logic       counter_clear,
  output logic       refresh_req,
  output logic [2:0] state
);

  localparam int unsigned NBTN = 3;
  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_LAP   = 1;
  localparam int unsigned BTN_CLEAR = 2;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_RUN       = 3'b001,
    ST_LAP       = 3'b010,
    ST_PAUSE     = 3'b011,
    ST_LAP_PAUSE = 3'b100
  } state_e;

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] sync1_q;
  logic [NBTN-1:0] sync2_q;
  logic [NBTN-1:0] level_q;
  logic [NBTN-1:0] event_q;
  logic [DB_W-1:0] cnt_q [NBTN];

  assign btn_raw = {btn_clear, btn_lap, btn_start_stop};

  // Two-flop synchroniser, mismatch-run counter and press-edge event per button
  always_ff @(posedge clk) begin
    if (res) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      event_q <= '0;
      for (int i = 0; i < NBTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < NBTN; i++) begin
        if (sync2_q[i] != level_q[i]) begin
          if (cnt_q[i] == DB_LAST) begin
            level_q[i] <= sync2_q[i];
            cnt_q[i]   <= '0;
            // Only the press edge (accepted 0->1) produces an event
            event_q[i] <= sync2_q[i];
          end else begin
            cnt_q[i]   <= cnt_q[i] + DB_W'(1);
            event_q[i] <= 1'b0;
          end
        end else begin
          cnt_q[i]   <= '0;
          event_q[i] <= 1'b0;
        end
      end
    end
  end

  logic ev_start;
  logic ev_lap;
  logic ev_clear;

  assign ev_start = event_q[BTN_START];
  assign ev_lap   = event_q[BTN_LAP];
  assign ev_clear = event_q[BTN_CLEAR];

  // ---------------------------------------------------------------------------
  // Auto-stop at full count (optional)
  // ---------------------------------------------------------------------------
  logic auto_stop;
  logic start_blocked;

`ifdef SW_AUTO_STOP_EN
  // The tick that reaches the maximum is the last increment; a full count
  // cannot be resumed, only cleared.
  assign auto_stop     = tick_100hz & at_max;
  assign start_blocked = at_max;
`else
  logic unused_at_max;
  assign unused_at_max = at_max;
  assign auto_stop     = 1'b0;
  assign start_blocked = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Run-control state machine
  // ---------------------------------------------------------------------------
  state_e state_q;
  state_e state_d;
  logic   clear_d;
  logic   ce_q;
  logic   de_q;
  logic   clear_q;

  // Next state: clear > start_stop > lap among the events the state honours
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev_clear) begin
          clear_d = 1'b1;
        end else if (ev_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (auto_stop || ev_start) begin
          state_d = ST_PAUSE;
        end else if (ev_lap) begin
          state_d = ST_LAP;
        end
      end
      ST_LAP: begin
        if (auto_stop || ev_start) begin
          state_d = ST_LAP_PAUSE;
        end else if (ev_lap) begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (ev_clear) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else if (ev_start && !start_blocked) begin
          state_d = ST_RUN;
        end
      end
      ST_LAP_PAUSE: begin
        if (ev_clear) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else if (ev_start) begin
          state_d = ST_LAP;
        end else if (ev_lap) begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with enables decoded from the next state so they align
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
      ce_q    <= 1'b0;
      de_q    <= 1'b1;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ce_q    <= (state_d == ST_RUN) || (state_d == ST_LAP);
      de_q    <= (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_PAUSE);
      clear_q <= clear_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Display refresh handshake
  // ---------------------------------------------------------------------------
  logic de_prev_q;
  logic req_q;
  logic req_d;
  logic pend_q;
  logic pend_d;
  logic trig_c;

  assign trig_c = (tick_100hz & de_q) | (de_q & ~de_prev_q) | clear_q;

  // Request/ack with a single coalescing pending flag
  always_comb begin
    req_d  = req_q;
    pend_d = pend_q;
    if (req_q) begin
      if (refresh_ack) begin
        req_d = 1'b0;
      end
      pend_d = pend_q | trig_c;
    end else if (pend_q || trig_c) begin
      req_d  = 1'b1;
      pend_d = 1'b0;
    end
  end

  // Handshake registers; de_prev starts high so reset exit is not a refresh
  always_ff @(posedge clk) begin
    if (res) begin
      de_prev_q <= 1'b1;
      req_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      de_prev_q <= de_q;
      req_q     <= req_d;
      pend_q    <= pend_d;
    end
  end

  assign counter_enable = ce_q;
  assign display_enable = de_q;
  assign counter_clear  = clear_q;
  assign refresh_req    = req_q;
  assign state          = 3'(state_q);

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Bench for stopwatch_ctrl_fsm: directed scenarios followed by random
// button/tick/ack traffic, checked every cycle against a flag-based model.
module tb_stopwatch_ctrl_fsm;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       res;
  logic       btn_ss;
  logic       btn_lap;
  logic       btn_clr;
  logic       tick;
  logic       at_max;
  logic       ack;
  logic       ce;
  logic       de;
  logic       cc;
  logic       req;
  logic [2:0] st;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl_fsm #(
    .DEBOUNCE_CYCLES(DB),
    .DB_W           (3)
  ) dut (
    .clk           (clk),
    .res           (res),
    .btn_start_stop(btn_ss),
    .btn_lap       (btn_lap),
    .btn_clear     (btn_clr),
    .tick_100hz    (tick),
    .at_max        (at_max),
    .refresh_ack   (ack),
    .counter_enable(ce),
    .display_enable(de),
    .counter_clear (cc),
    .refresh_req   (req),
    .state         (st)
  );

  // Reference model: stopwatch as idle/running/frozen flags
  bit m_pipe [3][2];
  int m_run_len [3];
  bit m_acc [3];
  bit m_ev [3];
  bit m_idle, m_run, m_frz, m_cc, m_de_prev, m_req, m_pend;

  function automatic logic [2:0] m_code();
    if (m_idle) return 3'd0;
    if (m_run)  return m_frz ? 3'd2 : 3'd1;
    return m_frz ? 3'd4 : 3'd3;
  endfunction

  task automatic model_edge();
    bit de_now, trig, ev_s, ev_l, ev_c, am, blk;
    bit raw [3];
    bit syn;
    if (res) begin
      for (int b = 0; b < 3; b++) begin
        m_pipe[b][0] = 0; m_pipe[b][1] = 0;
        m_run_len[b] = 0; m_acc[b] = 0; m_ev[b] = 0;
      end
      m_idle = 1; m_run = 0; m_frz = 0; m_cc = 0;
      m_de_prev = 1; m_req = 0; m_pend = 0;
      return;
    end
    // refresh handshake uses the outputs as they were before this edge
    de_now = !m_frz;
    trig = (tick && de_now) || (de_now && !m_de_prev) || m_cc;
    if (m_req) begin
      if (ack) m_req = 0;
      m_pend = m_pend || trig;
    end else if (m_pend || trig) begin
      m_req = 1;
      m_pend = 0;
    end
    m_de_prev = de_now;
    // control flow driven by last cycle's press events
    ev_s = m_ev[0]; ev_l = m_ev[1]; ev_c = m_ev[2];
`ifdef SW_AUTO_STOP_EN
    am = tick && at_max;
    blk = at_max;
`else
    am = 0;
    blk = 0;
`endif
    m_cc = 0;
    if (m_idle) begin
      if (ev_c) m_cc = 1;
      else if (ev_s) begin m_idle = 0; m_run = 1; end
    end else if (m_run) begin
      if (am || ev_s) m_run = 0;
      else if (ev_l) m_frz = !m_frz;
    end else begin
      if (ev_c) begin m_idle = 1; m_frz = 0; m_cc = 1; end
      else if (ev_s && !(blk && !m_frz)) m_run = 1;
      else if (ev_l && m_frz) m_frz = 0;
    end
    // debounce: a level is accepted after DB consecutive differing samples
    raw[0] = btn_ss; raw[1] = btn_lap; raw[2] = btn_clr;
    for (int b = 0; b < 3; b++) begin
      syn = m_pipe[b][1];
      m_ev[b] = 0;
      if (syn != m_acc[b]) begin
        m_run_len[b]++;
        if (m_run_len[b] == DB) begin
          m_acc[b] = syn;
          m_run_len[b] = 0;
          m_ev[b] = syn;
        end
      end else begin
        m_run_len[b] = 0;
      end
      m_pipe[b][1] = m_pipe[b][0];
      m_pipe[b][0] = raw[b];
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_state", st, m_code());
    chk("m_ce", {2'b0, ce}, {2'b0, m_run});
    chk("m_de", {2'b0, de}, {2'b0, !m_frz});
    chk("m_clear", {2'b0, cc}, {2'b0, m_cc});
    chk("m_req", {2'b0, req}, {2'b0, m_req});
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_ss = v;
      1: btn_lap = v;
      default: btn_clr = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    repeat (8) step();
    set_btn(b, 1'b0);
    repeat (8) step();
  endtask

  int hold_left [3];

  initial begin
    res = 1; btn_ss = 0; btn_lap = 0; btn_clr = 0;
    tick = 0; at_max = 0; ack = 0;
    repeat (2) step();
    res = 0;
    step();
    chk("rst_state", st, 3'd0);
    chk("rst_ce", {2'b0, ce}, 3'd0);
    chk("rst_de", {2'b0, de}, 3'd1);
    chk("rst_clear", {2'b0, cc}, 3'd0);
    chk("rst_req", {2'b0, req}, 3'd0);
    ack = 1;

    // press latency: state flips on the 7th edge after the press
    btn_ss = 1;
    repeat (6) step();
    chk("lat_pre", st, 3'd0);
    step();
    chk("lat_state", st, 3'd1);
    chk("lat_ce", {2'b0, ce}, 3'd1);
    chk("lat_de", {2'b0, de}, 3'd1);
    repeat (3) step();
    btn_ss = 0;
    repeat (10) step();
    chk("release", st, 3'd1);

    // bouncing press gives a single transition
    btn_ss = 1; step(); btn_ss = 0; step();
    btn_ss = 1; step(); btn_ss = 0; step();
    btn_ss = 1;
    repeat (10) step();
    btn_ss = 0;
    repeat (10) step();
    chk("bounce", st, 3'd3);

    // lap freezes display; ticks while frozen do not request a refresh
    press(0);
    chk("run", st, 3'd1);
    press(1);
    chk("lap_state", st, 3'd2);
    chk("lap_ce", {2'b0, ce}, 3'd1);
    chk("lap_de", {2'b0, de}, 3'd0);
    repeat (3) step();
    ack = 0; tick = 1;
    repeat (3) step();
    tick = 0;
    chk("lap_noreq", {2'b0, req}, 3'd0);
    press(1);
    chk("unlap_state", st, 3'd1);
    chk("unlap_de", {2'b0, de}, 3'd1);
    chk("unlap_req", {2'b0, req}, 3'd1);
    ack = 1;
    repeat (3) step();

    // start and clear together in PAUSE: clear wins
    press(0);
    chk("pause", st, 3'd3);
    btn_ss = 1; btn_clr = 1;
    repeat (6) step();
    step();
    chk("sc_state", st, 3'd0);
    chk("sc_clear", {2'b0, cc}, 3'd1);
    step();
    chk("sc_clear_end", {2'b0, cc}, 3'd0);
    chk("sc_state2", st, 3'd0);
    btn_ss = 0; btn_clr = 0;
    repeat (10) step();
    chk("sc_idle", st, 3'd0);

    // handshake: held request, coalesced pending, one low cycle
    press(0);
    repeat (3) step();
    ack = 0; tick = 1;
    step();
    tick = 0;
    chk("hs_raise", {2'b0, req}, 3'd1);
    repeat (5) begin
      tick = 1; step(); tick = 0; step();
    end
    chk("hs_hold", {2'b0, req}, 3'd1);
    ack = 1;
    step();
    ack = 0;
    chk("hs_drop", {2'b0, req}, 3'd0);
    step();
    chk("hs_pending", {2'b0, req}, 3'd1);
    ack = 1;
    repeat (3) step();

    // full count while running
    at_max = 1; tick = 1;
    step();
    tick = 0;
`ifdef SW_AUTO_STOP_EN
    chk("as_pause", st, 3'd3);
    press(0);
    chk("as_hold", st, 3'd3);
    press(2);
    chk("as_clear", st, 3'd0);
`else
    chk("as_ignored", st, 3'd1);
`endif
    at_max = 0;

    // random traffic against the model
    for (int b = 0; b < 3; b++) hold_left[b] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold_left[b] == 0) begin
          set_btn(b, ($urandom % 3) == 0);
          hold_left[b] = $urandom_range(1, 14);
        end else begin
          hold_left[b]--;
        end
      end
      tick   = ($urandom % 4) == 0;
      ack    = ($urandom % 3) == 0;
      at_max = ($urandom % 8) == 0;
      res    = ($urandom % 500) == 0;
      step();
    end
    res = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
